light_lum_quantizer: RTL and testbench



---
 rtl/light_pkg.sv | 24 ++
 rtl/light_lum_quantizer_if.sv | 22 ++
 rtl/lum_to_code.sv | 26 ++
 rtl/light_lum_quantizer.sv | 127 ++++++++++++
 tb/tb_light_lum_quantizer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the light sensing path: code width, idle code,
// lumen-to-code table constants and the quantizer FSM state type.
package light_pkg;

    localparam int          LIGHT_CODE_W     = 4;
    localparam logic [3:0]  LIGHT_IDLE_CODE  = 4'b1000;
    localparam int          LUM_BASE         = 6000;
    localparam int          LUM_STEP         = 500;
    localparam int          LUM_MAX_CODE_LUM = 13200;
    localparam int          NUM_THRESH       = 15;

    typedef enum logic [1:0] {
        ACCUM,
        QUANT,
        PUBLISH
    } state_t;

    // Lumen threshold that must be met for code k (k = 1..15). The top
    // step is clipped to 13200 lm rather than following the 500 lm ramp.
    function automatic int lum_threshold(input int k);
        return (k == NUM_THRESH) ? LUM_MAX_CODE_LUM : (LUM_BASE + LUM_STEP * k);
    endfunction

endpackage

// File: rtl/light_lum_quantizer_if.sv
// Sample handshake and code output bundle of the light lumen quantizer.
// master = sensor side / consumer, slave = the quantizer itself.
interface light_lum_quantizer_if #(
    parameter int LUM_W = 14
);
    logic [LUM_W-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;
    logic [3:0]       light_code;
    logic             code_valid;
    logic [LUM_W-1:0] avg_lum;

    modport master (
        output sample, sample_valid,
        input  sample_ready, light_code, code_valid, avg_lum
    );

    modport slave (
        input  sample, sample_valid,
        output sample_ready, light_code, code_valid, avg_lum
    );
endinterface

// File: rtl/lum_to_code.sv
// Combinational lumen-to-code mapper: the code is the number of table
// thresholds the average meets or exceeds, so no divider is needed.
module lum_to_code
    import light_pkg::*;
#(
    parameter int LUM_W = 14
) (
    input  logic [LUM_W-1:0]        avg,
    output logic [LIGHT_CODE_W-1:0] code
);

    logic [31:0] avg_ext;

    assign avg_ext = 32'(avg);

    // Threshold bank: count how many of T1..T15 the average reaches.
    always_comb begin
        code = '0;
        for (int k = 1; k <= NUM_THRESH; k++) begin
            if (avg_ext >= 32'(lum_threshold(k))) begin
                code = code + LIGHT_CODE_W'(1);
            end
        end
    end

endmodule

// File: rtl/light_lum_quantizer.sv
// Light lumen quantizer: averages windows of 2^LOG2_N raw lumen samples and
// publishes a 4-bit light code per window for the light controller.
// Optional macro LIGHT_LUM_QUANT_HYST_EN: a code is only published once two
// consecutive windows agree on it.
module light_lum_quantizer
    import light_pkg::*;
#(
    parameter int LUM_W  = 14,
    parameter int LOG2_N = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    light_lum_quantizer_if.slave  bus
);

    localparam int ACC_W = LUM_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_COUNT = '1;

    state_t                  state;
    state_t                  next_state;
    logic [ACC_W-1:0]        acc;
    logic [LOG2_N-1:0]       count;
    logic                    xfer;
    logic [LUM_W-1:0]        avg;
    logic [LIGHT_CODE_W-1:0] code;
    logic [LIGHT_CODE_W-1:0] light_code_q;
    logic [LUM_W-1:0]        avg_q;
    logic                    publish_q;
`ifdef LIGHT_LUM_QUANT_HYST_EN
    logic [LIGHT_CODE_W-1:0] cand_q;
`endif

    assign xfer = bus.sample_valid && bus.sample_ready;
    assign avg  = acc[ACC_W-1:LOG2_N];

    assign bus.light_code = light_code_q;
    assign bus.avg_lum    = avg_q;

    lum_to_code #(
        .LUM_W (LUM_W)
    ) u_lum_to_code (
        .avg  (avg),
        .code (code)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next state: dropping en abandons whatever is in flight.
    always_comb begin
        next_state = state;
        if (!en) begin
            next_state = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (xfer && (count == LAST_COUNT)) next_state = QUANT;
                QUANT:   next_state = PUBLISH;
                PUBLISH: next_state = ACCUM;
                default: next_state = ACCUM;
            endcase
        end
    end

    // Handshake and publish strobe; gated by en so a flush never pulses.
    always_comb begin
        bus.sample_ready = en && (state == ACCUM);
        bus.code_valid   = en && (state == PUBLISH) && publish_q;
    end

    // Window accumulation, averaging and code register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            count        <= '0;
            avg_q        <= '0;
            light_code_q <= LIGHT_IDLE_CODE;
            publish_q    <= 1'b0;
`ifdef LIGHT_LUM_QUANT_HYST_EN
            cand_q       <= LIGHT_IDLE_CODE;
`endif
        end else if (!en) begin
            acc   <= '0;
            count <= '0;
`ifdef LIGHT_LUM_QUANT_HYST_EN
            cand_q <= light_code_q;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        acc   <= acc + ACC_W'(bus.sample);
                        count <= count + LOG2_N'(1);
                    end
                end
                QUANT: begin
                    avg_q <= avg;
`ifdef LIGHT_LUM_QUANT_HYST_EN
                    cand_q    <= code;
                    publish_q <= (code == cand_q);
                    if (code == cand_q) begin
                        light_code_q <= code;
                    end
`else
                    publish_q    <= 1'b1;
                    light_code_q <= code;
`endif
                end
                PUBLISH: begin
                    acc   <= '0;
                    count <= '0;
                end
                default: begin
                    acc   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_lum_quantizer.sv
// Self-checking bench for light_lum_quantizer: directed and random windows
// compared every cycle against a window-level reference model.
module tb_light_lum_quantizer;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    light_lum_quantizer_if #(.LUM_W(14)) bus ();

    light_lum_quantizer #(
        .LUM_W  (14),
        .LOG2_N (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state (window level)
    int accepted[$];
    int busy;
    bit pend_cv;
    int exp_code;
    int exp_avg;
    int cand;
    int win[8];

    function automatic int ref_code(input int avg);
        if (avg >= 13200) return 15;
        if (avg < 6500) return 0;
        return (avg - 6000) / 500;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        accepted.delete();
        busy     = 0;
        pend_cv  = 0;
        exp_code = 8;
        exp_avg  = 0;
        cand     = 8;
    endtask

    task automatic model_step(input logic e, input bit xfer, input int s);
        int sum;
        int c;
        bit pub;
        if (!e) begin
            accepted.delete();
            busy    = 0;
            pend_cv = 0;
            cand    = exp_code;
        end else if (busy == 2) begin
            sum = 0;
            foreach (accepted[i]) sum += accepted[i];
            exp_avg = sum / 8;
            c = ref_code(exp_avg);
`ifdef LIGHT_LUM_QUANT_HYST_EN
            pub  = (c == cand);
            cand = c;
`else
            pub = 1'b1;
`endif
            if (pub) exp_code = c;
            pend_cv = pub;
            busy = 1;
        end else if (busy == 1) begin
            busy    = 0;
            pend_cv = 0;
            accepted.delete();
        end else if (xfer) begin
            accepted.push_back(s);
            if (accepted.size() == 8) busy = 2;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input int s, output bit xfer);
        bit exp_ready;
        bit exp_cv;
        @(posedge clk);
        #1;
        en               = e;
        bus.sample_valid = v;
        bus.sample       = 14'(s);
        @(negedge clk);
        exp_ready = e && (busy == 0);
        exp_cv    = e && (busy == 1) && pend_cv;
        checkOutput("sample_ready", int'(bus.sample_ready), int'(exp_ready));
        checkOutput("code_valid", int'(bus.code_valid), int'(exp_cv));
        checkOutput("light_code", int'(bus.light_code), exp_code);
        checkOutput("avg_lum", int'(bus.avg_lum), exp_avg);
        xfer = v && exp_ready;
        model_step(e, xfer, s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        en               = 1'b0;
        bus.sample_valid = 1'b0;
        rst_n            = 1'b0;
        #2;
        checkOutput("rst_light_code", int'(bus.light_code), 8);
        checkOutput("rst_code_valid", int'(bus.code_valid), 0);
        checkOutput("rst_sample_ready", int'(bus.sample_ready), 0);
        checkOutput("rst_avg_lum", int'(bus.avg_lum), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_samples(input int n, input int gap_pct);
        bit xfer;
        int tries;
        for (int i = 0; i < n; i++) begin
            xfer  = 1'b0;
            tries = 0;
            while (!xfer && tries < 64) begin
                applyStimulus(1'b1, ($urandom_range(99) >= gap_pct), win[i], xfer);
                tries++;
            end
            if (!xfer) checkOutput("xfer_timeout", 0, 1);
        end
    endtask

    task automatic idle(input int n, input logic e);
        bit xfer;
        for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 0, xfer);
    endtask

    task automatic fill_win(input int v);
        for (int i = 0; i < 8; i++) win[i] = v;
    endtask

    task automatic random_window();
        int base;
        int v;
        base = int'($urandom_range(14000, 5000));
        for (int i = 0; i < 8; i++) begin
            v = base + int'($urandom_range(600)) - 300;
            if (v > 16383) v = 16383;
            win[i] = v;
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        en               = 1'b0;
        bus.sample       = '0;
        bus.sample_valid = 1'b0;
        model_reset();

        do_reset();
        idle(3, 1'b1);

        fill_win(10000);
        send_samples(8, 0);
        idle(3, 1'b1);

        win = '{6000, 6000, 6000, 6000, 7000, 7000, 7000, 7000};
        send_samples(8, 0);
        fill_win(16383);
        send_samples(8, 0);
        fill_win(13100);
        send_samples(8, 0);
        idle(3, 1'b1);

        fill_win(3000);
        send_samples(8, 40);
        idle(3, 1'b1);

        fill_win(9000);
        send_samples(5, 0);
        idle(2, 1'b0);
        send_samples(8, 0);
        idle(3, 1'b1);

        fill_win(4000);
        send_samples(3, 0);
        do_reset();
        fill_win(9000);
        send_samples(8, 20);
        idle(3, 1'b1);

        fill_win(12000);
        send_samples(8, 0);
        fill_win(9000);
        send_samples(8, 0);
        send_samples(8, 0);
        idle(3, 1'b1);

        for (int w = 0; w < 8; w++) begin
            random_window();
            send_samples(8, 25);
            send_samples(8, 25);
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
